// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe: two-stage post-add normaliser and rounder.
// S1 renormalises the adder mantissa. A carry causes a 1-bit right shift;
// otherwise a leading-zero left shift is applied. S2 rounds to nearest-even,
// adjusts the exponent and raises the overflow/underflow/zero flags.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake
//   in_sign, in_exp, in_mant sign, pre-normalisation biased exponent,
//                            {carry, hidden, fraction, guard bits}
//   out_valid/out_ready      output handshake
//   out_sign, out_exp, out_frac  packable result fields
//   out_zero, out_of, out_uf, out_inexact  exception flags
module fp_norm_round_pipe #(
    parameter int FRAC_W = 23,
    parameter int EXP_W  = 8,
    parameter int GRD_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [FRAC_W+GRD_W+1:0]   in_mant,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sign,
    output logic [EXP_W-1:0]          out_exp,
    output logic [FRAC_W-1:0]         out_frac,
    output logic                      out_zero,
    output logic                      out_of,
    output logic                      out_uf,
    output logic                      out_inexact
);
    localparam int MANT_W = FRAC_W + GRD_W + 2;
    localparam int NRM_W  = MANT_W - 1;          // hidden bit down to last guard bit
    localparam int LZ_W   = $clog2(MANT_W);
    localparam int XE_W   = EXP_W + 2;           // signed extended exponent
    localparam logic signed [XE_W-1:0] EXP_MAX = XE_W'((1 << EXP_W) - 1);

    logic s1_adv;
    logic s2_adv;
    logic s1_valid;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // ---------------- S1: leading-zero count and shift ----------------
    logic [LZ_W-1:0]        lz;
    logic                   lz_found;
    logic [NRM_W-1:0]       n_mant;
    logic                   n_sticky;
    logic signed [XE_W-1:0] n_exp;
    logic                   n_zero;

    // Priority search from the hidden-bit position downward.
    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int unsigned i = 0; i < NRM_W; i++) begin
            if (!lz_found && in_mant[NRM_W-1-i]) begin
                lz       = LZ_W'(i);
                lz_found = 1'b1;
            end
        end
    end

    always_comb begin
        n_zero = (in_mant == '0);
        if (in_mant[MANT_W-1]) begin
            n_mant   = in_mant[MANT_W-1:1];
            n_sticky = in_mant[0];
            n_exp    = XE_W'(in_exp) + XE_W'(1);
        end else begin
            n_mant   = in_mant[NRM_W-1:0] << lz;
            n_sticky = 1'b0;
            n_exp    = XE_W'(in_exp) - XE_W'(lz);
        end
    end

    logic                   s1_sign;
    logic [NRM_W-1:0]       s1_mant;
    logic                   s1_sticky;
    logic signed [XE_W-1:0] s1_exp;
    logic                   s1_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_mant   <= '0;
            s1_sticky <= 1'b0;
            s1_exp    <= '0;
            s1_zero   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign   <= in_sign;
                s1_mant   <= n_mant;
                s1_sticky <= n_sticky;
                s1_exp    <= n_exp;
                s1_zero   <= n_zero;
            end
        end
    end

    // ---------------- S2: round, exponent adjust, exceptions ----------------
    logic [FRAC_W-1:0]      frac_t;
    logic                   g_bit;
    logic                   s_bit;
    logic                   rnd_up;
    logic                   rnd_co;
    logic [FRAC_W-1:0]      rnd_frac;
    logic signed [XE_W-1:0] exp_r;
    logic [EXP_W-1:0]       r_exp;
    logic [FRAC_W-1:0]      r_frac;
    logic                   r_zero;
    logic                   r_of;
    logic                   r_uf;
    logic                   r_inx;

    always_comb begin
        frac_t   = s1_mant[GRD_W +: FRAC_W];
        g_bit    = s1_mant[GRD_W-1];
        s_bit    = (|s1_mant[GRD_W-2:0]) | s1_sticky;
        rnd_up   = g_bit & (s_bit | frac_t[0]);
        // A carry out leaves the fraction bits all zero, which is the renormalised value.
        {rnd_co, rnd_frac} = {1'b0, frac_t} + (FRAC_W+1)'(rnd_up);
        exp_r    = s1_exp + XE_W'(rnd_co);

        r_exp    = exp_r[EXP_W-1:0];
        r_frac   = rnd_frac;
        r_zero   = 1'b0;
        r_of     = 1'b0;
        r_uf     = 1'b0;
        r_inx    = g_bit | s_bit;
        if (s1_zero) begin
            r_exp  = '0;
            r_frac = '0;
            r_zero = 1'b1;
            r_inx  = 1'b0;
        end else if (exp_r[XE_W-1] || exp_r == '0) begin
            r_exp  = '0;
            r_frac = '0;
            r_zero = 1'b1;
            r_uf   = 1'b1;
            r_inx  = 1'b1;
        end else if (exp_r >= EXP_MAX) begin
            r_exp  = '1;
            r_frac = '0;
            r_of   = 1'b1;
            r_inx  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_sign    <= 1'b0;
            out_exp     <= '0;
            out_frac    <= '0;
            out_zero    <= 1'b0;
            out_of      <= 1'b0;
            out_uf      <= 1'b0;
            out_inexact <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign    <= s1_sign;
                out_exp     <= r_exp;
                out_frac    <= r_frac;
                out_zero    <= r_zero;
                out_of      <= r_of;
                out_uf      <= r_uf;
                out_inexact <= r_inx;
            end
        end
    end
endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// tb_fp_norm_round_pipe: directed vectors for fp_norm_round_pipe at the
// default parameters, plus backpressure and mid-flight reset sequences.
module tb_fp_norm_round_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic        out_zero;
    logic        out_of;
    logic        out_uf;
    logic        out_inexact;

    int n_checks = 0;
    int n_fail   = 0;

    fp_norm_round_pipe #(.FRAC_W(23), .EXP_W(8), .GRD_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
        .out_zero(out_zero), .out_of(out_of), .out_uf(out_uf),
        .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] mant;
        logic        o_sign;
        logic [7:0]  o_exp;
        logic [22:0] o_frac;
        logic        o_zero;
        logic        o_of;
        logic        o_uf;
        logic        o_inx;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " out_valid"},   32'(out_valid),   32'd0);
        chk({tag, " out_sign"},    32'(out_sign),    32'd0);
        chk({tag, " out_exp"},     32'(out_exp),     32'd0);
        chk({tag, " out_frac"},    32'(out_frac),    32'd0);
        chk({tag, " out_zero"},    32'(out_zero),    32'd0);
        chk({tag, " out_of"},      32'(out_of),      32'd0);
        chk({tag, " out_uf"},      32'(out_uf),      32'd0);
        chk({tag, " out_inexact"}, 32'(out_inexact), 32'd0);
        chk({tag, " in_ready"},    32'(in_ready),    32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     rcv[$];
        int     sent;
        int     seen;
        logic   got;
        logic   stalled;
        logic [7:0] held_exp;

        //         sign exp   mant          osign oexp   ofrac       z  of uf inx
        vecs[0]  = '{1'b1, 8'd127, 28'h8000000, 1'b1, 8'd128, 23'h000000, 0, 0, 0, 0}; // carry path
        vecs[1]  = '{1'b0, 8'd10,  28'h0800000, 1'b0, 8'd7,   23'h000000, 0, 0, 0, 0}; // lz=3
        vecs[2]  = '{1'b0, 8'd127, 28'h7FFFFFC, 1'b0, 8'd128, 23'h000000, 0, 0, 0, 1}; // round carry-out
        vecs[3]  = '{1'b0, 8'd5,   28'h4000004, 1'b0, 8'd5,   23'h000000, 0, 0, 0, 1}; // tie, even stays
        vecs[4]  = '{1'b0, 8'd100, 28'h400000C, 1'b0, 8'd100, 23'h000002, 0, 0, 0, 1}; // tie, odd rounds up
        vecs[5]  = '{1'b0, 8'd10,  28'h0000008, 1'b0, 8'd0,   23'h000000, 1, 0, 1, 1}; // underflow
        vecs[6]  = '{1'b1, 8'd50,  28'h0000000, 1'b1, 8'd0,   23'h000000, 1, 0, 0, 0}; // exact zero
        vecs[7]  = '{1'b0, 8'd254, 28'h8000000, 1'b0, 8'd255, 23'h000000, 0, 1, 0, 1}; // overflow via carry
        vecs[8]  = '{1'b0, 8'd253, 28'h8000000, 1'b0, 8'd254, 23'h000000, 0, 0, 0, 0}; // largest normal
        vecs[9]  = '{1'b0, 8'd1,   28'h2000000, 1'b0, 8'd0,   23'h000000, 1, 0, 1, 1}; // exp_n == 0
        vecs[10] = '{1'b1, 8'd2,   28'h2000000, 1'b1, 8'd1,   23'h000000, 0, 0, 0, 0}; // exp_n == 1
        vecs[11] = '{1'b0, 8'd20,  28'h8000001, 1'b0, 8'd21,  23'h000000, 0, 0, 0, 1}; // shifted-out sticky
        vecs[12] = '{1'b0, 8'd254, 28'h7FFFFFC, 1'b0, 8'd255, 23'h000000, 0, 1, 0, 1}; // overflow via rounding
        vecs[13] = '{1'b0, 8'd60,  28'h800000F, 1'b0, 8'd61,  23'h000001, 0, 0, 0, 1}; // carry + round up
        vecs[14] = '{1'b0, 8'd30,  28'h5555555, 1'b0, 8'd30,  23'h2AAAAB, 0, 0, 0, 1}; // above half
        vecs[15] = '{1'b1, 8'd100, 28'h0000007, 1'b1, 8'd76,  23'h600000, 0, 0, 0, 0}; // lz=24

        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle("reset");

        // Directed vectors, one at a time.
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            in_sign = vecs[v].sign; in_exp = vecs[v].exp; in_mant = vecs[v].mant;
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk($sformatf("v%0d in_ready", v), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                @(negedge clk);
                if (out_valid) got = 1'b1;
            end
            chk($sformatf("v%0d out_valid", v), 32'(got), 32'd1);
            chk($sformatf("v%0d sign", v),    32'(out_sign),    32'(vecs[v].o_sign));
            chk($sformatf("v%0d exp", v),     32'(out_exp),     32'(vecs[v].o_exp));
            chk($sformatf("v%0d frac", v),    32'(out_frac),    32'(vecs[v].o_frac));
            chk($sformatf("v%0d zero", v),    32'(out_zero),    32'(vecs[v].o_zero));
            chk($sformatf("v%0d of", v),      32'(out_of),      32'(vecs[v].o_of));
            chk($sformatf("v%0d uf", v),      32'(out_uf),      32'(vecs[v].o_uf));
            chk($sformatf("v%0d inexact", v), 32'(out_inexact), 32'(vecs[v].o_inx));
        end

        // Backpressure: 4 words, exps 1..4, out_ready low for 5 cycles.
        @(negedge clk);
        sent = 0; stalled = 1'b0; held_exp = '0;
        for (int cyc = 0; cyc < 30 && rcv.size() < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (stalled) begin
                chk("bp stall valid", 32'(out_valid), 32'd1);
                chk("bp stall exp",   32'(out_exp),   32'(held_exp));
            end
            out_ready = (cyc >= 5);
            if (sent < 4) begin
                in_valid = 1'b1; in_sign = 1'b0; in_mant = 28'h4000000;
                in_exp = 8'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 2) chk("bp in_ready low with 2 held", 32'(in_ready), 32'd0);
            if (cyc == 1) chk("bp in_ready high with 1 held", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) rcv.push_back(int'(out_exp));
            if (in_valid && in_ready) sent++;
            stalled  = out_valid && !out_ready;
            held_exp = out_exp;
        end
        in_valid = 1'b0;
        chk("bp count", 32'(rcv.size()), 32'd4);
        for (int i = 0; i < rcv.size(); i++)
            chk($sformatf("bp order %0d", i), 32'(rcv[i]), 32'(i + 1));

        // Reset with two words in flight.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_sign = 1'b1; in_mant = 28'h4000008; in_exp = 8'd9;
        @(negedge clk);
        in_exp = 8'd11;
        @(negedge clk);
        chk("rst pre out_valid", 32'(out_valid), 32'd1);
        in_exp = 8'd13; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk_idle("rst mid");
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst discarded words", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_norm_round_pipe.md
Name: fp_norm_round_pipe

Overview:
- Parametrised, pipelined post-add normaliser and rounder for the FPU adder datapath.
- Takes the raw add/sub mantissa (carry bit, hidden bit, fraction, guard bits) plus the pre-normalisation biased exponent.
- Normalises by one-bit right shift on carry, or leading-zero left shift. Applies round-to-nearest-even and re-normalises on rounding carry-out.
- Produces a packable sign/exponent/fraction with IEEE exception flags. Sits between the mantissa adder and the result packer, with valid/ready flow control.

Parameters:
- FRAC_W, 23, stored fraction width.
- EXP_W, 8, biased exponent width.
- GRD_W, 3, extra low-order bits below the fraction LSB; must be >= 2. The MSB is guard; the rest feed sticky.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input this cycle.
- in_sign  in  1  result sign; passed through unchanged.
- in_exp  in  EXP_W  biased exponent before normalisation.
- in_mant  in  FRAC_W+GRD_W+2  layout, MSB first: carry, hidden, fraction, guard bits.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_sign  out  1  result sign.
- out_exp  out  EXP_W  normalised, rounded biased exponent.
- out_frac  out  FRAC_W  rounded fraction, hidden bit removed.
- out_zero  out  1  result is exact zero.
- out_of  out  1  overflow; result forced to infinity.
- out_uf  out  1  underflow; result flushed to zero.
- out_inexact  out  1  guard or sticky bits were nonzero.

Behaviour:
- **Pipeline:** two registered stages. S1 performs the leading-zero count and shift. S2 performs rounding, exponent adjust and exception handling.
- **Latency:** an accepted input (in_valid & in_ready at edge N) appears on the outputs, with out_valid=1, after edge N+2 when unstalled. Throughput is one per cycle.
- **Handshake:**
  - S2 advances when it is empty or out_ready=1.
  - S1 advances when it is empty or S2 advances.
  - in_ready = S1 advances; it is combinational from out_ready.
  - Output fields are held stable while out_valid=1 and out_ready=0.
  - No loss, duplication or reordering.
  - in_valid is ignored when in_ready=0.
- **Reset:** clears both stage valids. Outputs reset to out_valid=0, with all data and flag outputs 0. in_ready=1 in the first cycle after reset. In-flight words are discarded; reset overrides a simultaneous accept.
- **S1, carry=1:**
  - Shift right by 1; the bit shifted out is ORed into sticky.
  - exp_n = in_exp+1, computed EXP_W+1 bits wide.
- **S1, carry=0 and mant nonzero:**
  - lz = number of zeros above the first 1, counted from the hidden-bit position.
  - Shift left by lz, zero-filled.
  - exp_n = in_exp - lz, signed, EXP_W+2 bits wide.
- **S1, mant all zero:** mark zero. Result is exp=0, frac=0, zero=1; no other flags.
- **S2 rounding (RNE):**
  - G = guard MSB; S = OR of the remaining guard bits.
  - Round up iff G & (S | frac LSB).
  - inexact = G | S.
  - If rounding carries out of the fraction: frac=0, exp_n+1.
- **S2 underflow:** if exp_n <= 0, flush to zero. Result is exp=0, frac=0, uf=1, zero=1, inexact=1. No denormals are produced.
- **S2 overflow:** if exp_n >= 2^EXP_W-1 (after rounding): exp=all ones, frac=0, of=1, inexact=1.
- **Flag exclusivity:** of, uf and the exact-zero case are mutually exclusive.

Test Plan:
- **Carry path:** in_mant=28'h8000000, in_exp=127, in_sign=1, out_ready=1 → 2 cycles later: sign=1, exp=128, frac=0, all flags 0.
- **Left shift:** in_mant=28'h0800000 (lz=3), in_exp=10 → exp=7, frac=0, inexact=0.
- **Rounding:**
  - Round-up with carry-out: in_mant=28'h7FFFFFC, in_exp=127 → exp=128, frac=0, inexact=1.
  - Tie-to-even: in_mant=28'h4000004, in_exp=5 → exp=5, frac=0, inexact=1.
- **Exceptions:**
  - Underflow: in_mant=28'h0000008, in_exp=10 → exp=0, frac=0, uf=1, zero=1.
  - Exact zero: in_mant=0 → zero=1, inexact=0.
  - Overflow: in_mant=28'h8000000, in_exp=254 → exp=255, frac=0, of=1.
- **Backpressure:**
  - Stimulus: 4 back-to-back inputs with exponents 1, 2, 3, 4; out_ready=0 for 5 cycles, then 1.
  - Required: in_ready drops once 2 words are held; outputs stay stable while stalled; exponents emerge in order 1, 2, 3, 4 with no duplicates.
- **Reset mid-operation:** assert rst for 1 cycle with 2 words in flight → out_valid=0 next cycle, all outputs 0, in_ready=1; both words are never emitted.
